mem_wb_unit: RTL and testbench
==============================

# mem_wb_unit

Parametrised memory-access and write-back stage for the micropro core. It sits after the ALU and owns the data memory. It accepts one decoded instruction at a time through a valid/ready handshake and performs byte, half-word or word loads and stores with a configurable memory latency. It then emits a single registered write-back beat toward the register file. Compared with the earlier stage, it adds sub-word access, sign extension, misalignment detection, a multi-cycle access state machine and halt latching.

## Interface
- DEPTH, 256: data memory size in 32-bit words; power of two, ≥ 4.
- MEM_LAT, 1: wait cycles spent in MEM before the access completes; ≥ 1.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  instruction present.
- in_ready  out  1  stage can accept; high only in IDLE.
- reg_we  in  1  instruction writes a register.
- is_load, is_store, is_halt  in  1 each  operation class.
- mem_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- load_unsigned  in  1  zero-extend sub-word loads.
- dstreg_num  in  5  destination register.
- op2  in  32  store data.
- alu_result  in  32  byte address for load/store; result for other ops.
- wb_valid  out  1  one-cycle write-back beat.
- wb_we  out  1  register-file write enable; qualified by wb_valid.
- wb_num  out  5  destination register.
- wb_data  out  32  write-back data.
- misalign  out  1  pulses with wb_valid when the access was rejected.
- halted  out  1  sticky halt flag.

## Operation
- States: IDLE, MEM, WB, HALT.
- Accept: in_valid && in_ready. Inputs are captured on accept, so they may change afterwards.
- Priority: is_halt > is_load > is_store > ALU op.
- IDLE to HALT on an accepted halt. halted=1 and in_ready=0 until rst. No wb beat is issued.
- IDLE to WB on an accepted ALU op, with wb_data = alu_result.
- Misaligned load or store (half with addr[0]=1, or word with addr[1:0]≠0): IDLE to WB. No memory access occurs, wb_we=0 and misalign=1.
- Aligned load or store: IDLE to MEM. A down-counter is loaded with MEM_LAT-1.
  - MEM holds until the counter reaches 0.
  - On that final MEM cycle, a store writes memory and a load samples memory.
  - The state then moves to WB.
- WB: wb_valid=1 for exactly one cycle, then IDLE.
- Address rules:
  - Word index = alu_result[log2(DEPTH)+1:2]. Upper bits are ignored, so addresses wrap modulo DEPTH words.
  - Byte lane = addr[1:0]; half lane = addr[1]. Byte 0 is bits [7:0] (little-endian).
- Store: only the addressed lanes are written, from op2[7:0], op2[15:0] or op2[31:0]. Other bytes are preserved. wb_we=0.
- Load: the lane is extracted and right-justified. It is sign-extended unless load_unsigned=1. Word loads ignore load_unsigned.
- wb_we = reg_we && !store && !misalign && (dstreg_num≠0). Register 0 is never written.
- Memory contents are not reset.

## Timing
- Reset values: state IDLE, in_ready=1 (first cycle after rst deasserts), wb_valid=0, wb_we=0, wb_num=0, wb_data=0, misalign=0, halted=0, counter=0.
- All outputs are registered.
- Latency, measured from the accept edge to the wb_valid cycle:
  - ALU op or misaligned access: 1 cycle.
  - Aligned load or store: MEM_LAT+1 cycles.
- Throughput: one instruction per (latency+1) cycles. in_ready is low from the accept edge through the WB cycle.
- wb_num, wb_data, wb_we and misalign hold their values outside WB. They are meaningful only when wb_valid=1.
- rst mid-operation: the state returns to IDLE and no wb beat is issued. A store still in MEM before its final cycle is not written. A store already written stays written.
- rst clears halted.
- A load from an address stored by the immediately preceding instruction returns the new data, because accesses are strictly serialised.

## Test plan
- Word store then load, MEM_LAT=1: store 0xDEADBEEF to 0x10, then load word from 0x10 into r5. Required: wb_valid two cycles after each accept; the load returns wb_data=0xDEADBEEF, wb_we=1, wb_num=5.
- Byte merge and extension: after the above, store byte 0x80 to 0x11. A signed byte load from 0x11 returns 0xFFFFFF80; an unsigned one returns 0x00000080. A word load from 0x10 returns 0xDEAD80EF.
- Misalignment: a half load from 0x21 returns misalign=1 and wb_we=0 with 1-cycle latency. A following word load from 0x20 shows memory unchanged.
- Latency and wrap, MEM_LAT=3, DEPTH=256:
  - A store to 0x400 completes 4 cycles after accept.
  - A load from 0x000 returns the same data.
  - in_ready stays low for 4 cycles.
- Halt and r0: an ALU op with dstreg_num=0 and reg_we=1 gives wb_we=0. A halt then sets halted=1 and in_ready=0, and later in_valid is ignored. rst clears both.
- Reset mid-store, MEM_LAT=3: assert rst in the second MEM cycle. Required: no wb_valid, and a later load shows the old data.

Source files
------------

// File: rtl/mem_wb_unit_if.sv
// Instruction handshake into mem_wb_unit and its registered write-back beat.
// master drives the decoded instruction; slave is the memory/write-back stage.
interface mem_wb_unit_if;
   logic        in_valid;
   logic        in_ready;
   logic        reg_we;
   logic        is_load;
   logic        is_store;
   logic        is_halt;
   logic [1:0]  mem_size;
   logic        load_unsigned;
   logic [4:0]  dstreg_num;
   logic [31:0] op2;
   logic [31:0] alu_result;
   logic        wb_valid;
   logic        wb_we;
   logic [4:0]  wb_num;
   logic [31:0] wb_data;
   logic        misalign;
   logic        halted;

   modport master (
      output in_valid, reg_we, is_load, is_store, is_halt, mem_size,
             load_unsigned, dstreg_num, op2, alu_result,
      input  in_ready, wb_valid, wb_we, wb_num, wb_data, misalign, halted
   );

   modport slave (
      input  in_valid, reg_we, is_load, is_store, is_halt, mem_size,
             load_unsigned, dstreg_num, op2, alu_result,
      output in_ready, wb_valid, wb_we, wb_num, wb_data, misalign, halted
   );
endinterface

// File: rtl/mem_wb_unit.sv
// Memory-access / write-back stage: byte/half/word loads and stores, one beat out per instruction.
// Latency 1 (ALU op, misaligned) or MEM_LAT+1 (aligned access); in_ready only in IDLE, no overlap.
module mem_wb_unit #(
   parameter int DEPTH   = 256,
   parameter int MEM_LAT = 1
) (
   input logic          clk,
   input logic          rst,
   mem_wb_unit_if.slave bus_if
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   typedef enum logic [1:0] {IDLE, MEM, WB, HALT} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ld_q, ld_d;
   logic             st_q, st_d;
   logic [1:0]       size_q, size_d;
   logic             uns_q, uns_d;
   logic [AW+1:0]    addr_q, addr_d;
   logic [31:0]      op2_q, op2_d;
   logic [4:0]       dst_q, dst_d;
   logic             we_q, we_d;
   logic             wb_valid_q, wb_valid_d;
   logic             wb_we_q, wb_we_d;
   logic [4:0]       wb_num_q, wb_num_d;
   logic [31:0]      wb_data_q, wb_data_d;
   logic             mis_q, mis_d;

   logic [31:0]      mem_q [DEPTH];

   logic             accept;
   logic             acc_in;
   logic             mis_in;
   logic             we_in;
   logic             mem_wr;
   logic [31:0]      rd_word;
   logic [31:0]      rd_shift;
   logic [31:0]      ld_val;
   logic [3:0]       be;
   logic [31:0]      wdat;

   assign accept = bus_if.in_valid && (state_q == IDLE);
   assign acc_in = bus_if.is_load || bus_if.is_store;
   assign we_in  = bus_if.reg_we && (bus_if.dstreg_num != 5'd0);

   always_comb begin
      case (bus_if.mem_size)
         2'b00:   mis_in = 1'b0;
         2'b01:   mis_in = bus_if.alu_result[0];
         default: mis_in = |bus_if.alu_result[1:0];
      endcase
   end

   // Right-justify the addressed lane; a half access has addr[0]=0, so the same shift works.
   assign rd_word  = mem_q[addr_q[AW+1:2]];
   assign rd_shift = rd_word >> {addr_q[1:0], 3'b000};

   always_comb begin
      case (size_q)
         2'b00:   ld_val = uns_q ? {24'h0, rd_shift[7:0]}  : {{24{rd_shift[7]}}, rd_shift[7:0]};
         2'b01:   ld_val = uns_q ? {16'h0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
         default: ld_val = rd_word;
      endcase
   end

   always_comb begin
      case (size_q)
         2'b00: begin
            be   = 4'b0001 << addr_q[1:0];
            wdat = {4{op2_q[7:0]}};
         end
         2'b01: begin
            be   = 4'b0011 << {addr_q[1], 1'b0};
            wdat = {2{op2_q[15:0]}};
         end
         default: begin
            be   = 4'b1111;
            wdat = op2_q;
         end
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ld_d       = ld_q;
      st_d       = st_q;
      size_d     = size_q;
      uns_d      = uns_q;
      addr_d     = addr_q;
      op2_d      = op2_q;
      dst_d      = dst_q;
      we_d       = we_q;
      wb_valid_d = 1'b0;
      wb_we_d    = wb_we_q;
      wb_num_d   = wb_num_q;
      wb_data_d  = wb_data_q;
      mis_d      = mis_q;
      mem_wr     = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               ld_d   = bus_if.is_load;
               st_d   = !bus_if.is_load && bus_if.is_store;
               size_d = bus_if.mem_size;
               uns_d  = bus_if.load_unsigned;
               addr_d = bus_if.alu_result[AW+1:0];
               op2_d  = bus_if.op2;
               dst_d  = bus_if.dstreg_num;
               we_d   = we_in;
               if (bus_if.is_halt) begin
                  state_d = HALT;
               end else if (acc_in && mis_in) begin
                  state_d    = WB;
                  wb_valid_d = 1'b1;
                  wb_we_d    = 1'b0;
                  wb_num_d   = bus_if.dstreg_num;
                  mis_d      = 1'b1;
               end else if (acc_in) begin
                  state_d = MEM;
                  cnt_d   = CW'(MEM_LAT - 1);
               end else begin
                  state_d    = WB;
                  wb_valid_d = 1'b1;
                  wb_we_d    = we_in;
                  wb_num_d   = bus_if.dstreg_num;
                  wb_data_d  = bus_if.alu_result;
                  mis_d      = 1'b0;
               end
            end
         end
         MEM: begin
            if (cnt_q == '0) begin
               state_d    = WB;
               wb_valid_d = 1'b1;
               wb_num_d   = dst_q;
               mis_d      = 1'b0;
               wb_we_d    = ld_q && we_q;
               mem_wr     = st_q;
               if (ld_q) begin
                  wb_data_d = ld_val;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         WB:      state_d = IDLE;
         HALT:    state_d = HALT;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         ld_q       <= 1'b0;
         st_q       <= 1'b0;
         size_q     <= 2'b00;
         uns_q      <= 1'b0;
         addr_q     <= '0;
         op2_q      <= 32'h0;
         dst_q      <= 5'd0;
         we_q       <= 1'b0;
         wb_valid_q <= 1'b0;
         wb_we_q    <= 1'b0;
         wb_num_q   <= 5'd0;
         wb_data_q  <= 32'h0;
         mis_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ld_q       <= ld_d;
         st_q       <= st_d;
         size_q     <= size_d;
         uns_q      <= uns_d;
         addr_q     <= addr_d;
         op2_q      <= op2_d;
         dst_q      <= dst_d;
         we_q       <= we_d;
         wb_valid_q <= wb_valid_d;
         wb_we_q    <= wb_we_d;
         wb_num_q   <= wb_num_d;
         wb_data_q  <= wb_data_d;
         mis_q      <= mis_d;
      end
   end

   // Data memory is never reset; a reset arriving on the final MEM cycle cancels the store.
   always_ff @(posedge clk) begin
      if (mem_wr && !rst) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
               mem_q[addr_q[AW+1:2]][8*i +: 8] <= wdat[8*i +: 8];
            end
         end
      end
   end

   assign bus_if.in_ready = (state_q == IDLE);
   assign bus_if.halted   = (state_q == HALT);
   assign bus_if.wb_valid = wb_valid_q;
   assign bus_if.wb_we    = wb_we_q;
   assign bus_if.wb_num   = wb_num_q;
   assign bus_if.wb_data  = wb_data_q;
   assign bus_if.misalign = mis_q;
endmodule

// File: tb/tb_mem_wb_unit.sv
// Bench for mem_wb_unit: one instance with MEM_LAT=1 and one with MEM_LAT=3 share the stimulus drivers.
module tb_mem_wb_unit;
   localparam int DEPTH = 256;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int          sel = 0;
   logic        d_valid = 0, d_reg_we = 0, d_load = 0, d_store = 0, d_halt = 0, d_uns = 0;
   logic [1:0]  d_size = 0;
   logic [4:0]  d_dst = 0;
   logic [31:0] d_op2 = 0, d_alu = 0;

   logic        o_ready, o_wbv, o_we, o_mis, o_halted;
   logic [4:0]  o_num;
   logic [31:0] o_dat;

   int checks = 0;
   int errors = 0;

   int          r_lat, r_rl, r_nwb;
   logic        r_we, r_mis;
   logic [4:0]  r_num;
   logic [31:0] r_dat;

   logic [7:0]  mm [2][DEPTH*4];

   mem_wb_unit_if ifa ();
   mem_wb_unit_if ifb ();

   mem_wb_unit #(.DEPTH(DEPTH), .MEM_LAT(1)) dut_a (.clk(clk), .rst(rst), .bus_if(ifa));
   mem_wb_unit #(.DEPTH(DEPTH), .MEM_LAT(3)) dut_b (.clk(clk), .rst(rst), .bus_if(ifb));

   assign ifa.in_valid = d_valid && (sel == 0);
   assign ifb.in_valid = d_valid && (sel == 1);
   assign ifa.reg_we = d_reg_we;         assign ifb.reg_we = d_reg_we;
   assign ifa.is_load = d_load;          assign ifb.is_load = d_load;
   assign ifa.is_store = d_store;        assign ifb.is_store = d_store;
   assign ifa.is_halt = d_halt;          assign ifb.is_halt = d_halt;
   assign ifa.mem_size = d_size;         assign ifb.mem_size = d_size;
   assign ifa.load_unsigned = d_uns;     assign ifb.load_unsigned = d_uns;
   assign ifa.dstreg_num = d_dst;        assign ifb.dstreg_num = d_dst;
   assign ifa.op2 = d_op2;               assign ifb.op2 = d_op2;
   assign ifa.alu_result = d_alu;        assign ifb.alu_result = d_alu;

   always_comb begin
      if (sel == 0) begin
         o_ready = ifa.in_ready; o_wbv = ifa.wb_valid; o_we = ifa.wb_we; o_mis = ifa.misalign;
         o_halted = ifa.halted;  o_num = ifa.wb_num;   o_dat = ifa.wb_data;
      end else begin
         o_ready = ifb.in_ready; o_wbv = ifb.wb_valid; o_we = ifb.wb_we; o_mis = ifb.misalign;
         o_halted = ifb.halted;  o_num = ifb.wb_num;   o_dat = ifb.wb_data;
      end
   end

   // Present one instruction, wait (bounded) for accept, then watch until in_ready returns.
   task automatic issue(input int u, input logic ld, input logic st, input logic hl, input logic rwe,
                        input logic [1:0] sz, input logic un, input logic [4:0] dst,
                        input logic [31:0] a, input logic [31:0] od);
      int k;
      sel = u;
      d_load = ld; d_store = st; d_halt = hl; d_reg_we = rwe; d_size = sz; d_uns = un;
      d_dst = dst; d_alu = a; d_op2 = od; d_valid = 1'b1;
      #1;
      k = 0;
      while (o_ready !== 1'b1 && k < 20) begin
         @(posedge clk); #1; k++;
      end
      @(posedge clk); #1;
      d_valid = 1'b0;
      d_alu = $urandom; d_op2 = $urandom; d_dst = 5'($urandom); d_size = 2'($urandom);
      d_uns = 1'($urandom); d_reg_we = 1'($urandom);
      d_load = 1'b0; d_store = 1'b0; d_halt = 1'b0;
      r_lat = 0; r_rl = 0; r_nwb = 0; r_we = 1'bx; r_mis = 1'bx; r_num = 'x; r_dat = 'x;
      for (int c = 1; c <= 12; c++) begin
         if (o_wbv === 1'b1) begin
            r_nwb++;
            if (r_lat == 0) begin
               r_lat = c; r_we = o_we; r_mis = o_mis; r_num = o_num; r_dat = o_dat;
            end
         end
         if (o_ready !== 1'b1) r_rl++;
         else break;
         @(posedge clk); #1;
      end
   endtask

   // Reference: byte-addressed memory per instance, with alignment and extension from first principles.
   task automatic model_op(input int u, input logic ld, input logic st, input logic rwe,
                           input logic [1:0] sz, input logic un, input logic [4:0] dst,
                           input logic [31:0] a, input logic [31:0] od,
                           output int e_lat, output logic e_we, output logic e_mis,
                           output logic [31:0] e_dat, output logic e_dchk);
      int nb, base;
      logic is_mem, is_st;
      longint v;
      is_mem = ld || st;
      is_st  = !ld && st;
      nb     = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      base   = int'(a % (DEPTH * 4));
      e_mis  = is_mem && ((base % nb) != 0);
      e_we   = rwe && !is_st && !e_mis && (dst != 5'd0);
      e_dchk = 1'b0;
      e_dat  = 32'h0;
      if (!is_mem) begin
         e_lat = 1; e_dat = a; e_dchk = 1'b1;
      end else if (e_mis) begin
         e_lat = 1;
      end else begin
         e_lat = ((u == 0) ? 1 : 3) + 1;
         if (is_st) begin
            for (int i = 0; i < nb; i++) mm[u][base + i] = od[8*i +: 8];
         end else begin
            v = 0;
            for (int i = 0; i < nb; i++) v = v + (longint'(mm[u][base + i]) << (8 * i));
            if (nb < 4 && !un && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
            e_dat = 32'(v); e_dchk = 1'b1;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int u = 0; u < 2; u++) begin
         sel = u; #1;
         checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_ready u%0d got %b exp 1", u, o_ready); end
         checks++; if (o_wbv !== 1'b0) begin errors++; $display("FAIL rst_wb_valid u%0d got %b exp 0", u, o_wbv); end
         checks++; if (o_we !== 1'b0) begin errors++; $display("FAIL rst_wb_we u%0d got %b exp 0", u, o_we); end
         checks++; if (o_num !== 5'd0) begin errors++; $display("FAIL rst_wb_num u%0d got %0d exp 0", u, o_num); end
         checks++; if (o_dat !== 32'h0) begin errors++; $display("FAIL rst_wb_data u%0d got %h exp 0", u, o_dat); end
         checks++; if (o_mis !== 1'b0) begin errors++; $display("FAIL rst_misalign u%0d got %b exp 0", u, o_mis); end
         checks++; if (o_halted !== 1'b0) begin errors++; $display("FAIL rst_halted u%0d got %b exp 0", u, o_halted); end
      end
   endtask

   task automatic test_word_store_load();
      issue(0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 5'd3, 32'h10, 32'hDEADBEEF);
      checks++; if (r_lat != 2) begin errors++; $display("FAIL sw_latency got %0d exp 2", r_lat); end
      checks++; if (r_we !== 1'b0) begin errors++; $display("FAIL sw_wb_we got %b exp 0", r_we); end
      checks++; if (r_nwb != 1) begin errors++; $display("FAIL sw_beats got %0d exp 1", r_nwb); end
      issue(0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 5'd5, 32'h10, 32'h0);
      checks++; if (r_lat != 2) begin errors++; $display("FAIL lw_latency got %0d exp 2", r_lat); end
      checks++; if (r_dat !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got %h exp deadbeef", r_dat); end
      checks++; if (r_we !== 1'b1) begin errors++; $display("FAIL lw_wb_we got %b exp 1", r_we); end
      checks++; if (r_num !== 5'd5) begin errors++; $display("FAIL lw_wb_num got %0d exp 5", r_num); end
   endtask

   task automatic test_byte_merge();
      issue(0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 32'h11, 32'h55555580);
      issue(0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 5'd6, 32'h11, 32'h0);
      checks++; if (r_dat !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_signed got %h exp ffffff80", r_dat); end
      issue(0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 5'd6, 32'h11, 32'h0);
      checks++; if (r_dat !== 32'h00000080) begin errors++; $display("FAIL lb_unsigned got %h exp 00000080", r_dat); end
      issue(0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 5'd6, 32'h10, 32'h0);
      checks++; if (r_dat !== 32'hDEAD80EF) begin errors++; $display("FAIL lw_merged got %h exp dead80ef", r_dat); end
      issue(0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 5'd6, 32'h12, 32'h0);
      checks++; if (r_dat !== 32'hFFFFDEAD) begin errors++; $display("FAIL lh_signed got %h exp ffffdead", r_dat); end
   endtask

   task automatic test_misalign();
      issue(0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 5'd0, 32'h20, 32'h12345678);
      issue(0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 5'd7, 32'h21, 32'h0);
      checks++; if (r_mis !== 1'b1) begin errors++; $display("FAIL mis_half_flag got %b exp 1", r_mis); end
      checks++; if (r_we !== 1'b0) begin errors++; $display("FAIL mis_half_we got %b exp 0", r_we); end
      checks++; if (r_lat != 1) begin errors++; $display("FAIL mis_half_latency got %0d exp 1", r_lat); end
      issue(0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 5'd0, 32'h22, 32'hFFFFFFFF);
      checks++; if (r_mis !== 1'b1) begin errors++; $display("FAIL mis_word_store_flag got %b exp 1", r_mis); end
      issue(0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 5'd7, 32'h20, 32'h0);
      checks++; if (r_dat !== 32'h12345678) begin errors++; $display("FAIL mis_mem_unchanged got %h exp 12345678", r_dat); end
      checks++; if (r_mis !== 1'b0) begin errors++; $display("FAIL mis_clear got %b exp 0", r_mis); end
   endtask

   task automatic test_latency_wrap();
      issue(1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 5'd2, 32'h400, 32'hC0FFEE11);
      checks++; if (r_lat != 4) begin errors++; $display("FAIL lat3_store got %0d exp 4", r_lat); end
      checks++; if (r_rl != 4) begin errors++; $display("FAIL lat3_ready_low got %0d exp 4", r_rl); end
      issue(1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 5'd8, 32'h000, 32'h0);
      checks++; if (r_lat != 4) begin errors++; $display("FAIL lat3_load got %0d exp 4", r_lat); end
      checks++; if (r_dat !== 32'hC0FFEE11) begin errors++; $display("FAIL wrap_data got %h exp c0ffee11", r_dat); end
   endtask

   task automatic test_reset_mid_store();
      int nwb, k;
      issue(1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 5'd0, 32'h40, 32'hA5A50F0F);
      sel = 1; d_load = 1'b0; d_store = 1'b1; d_size = 2'd2; d_alu = 32'h40; d_op2 = 32'h12345678;
      d_valid = 1'b1; #1;
      k = 0;
      while (o_ready !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
      @(posedge clk); #1;
      d_valid = 1'b0; nwb = 0;
      if (o_wbv === 1'b1) nwb++;
      @(posedge clk); #1;
      rst = 1'b1;
      if (o_wbv === 1'b1) nwb++;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (6) begin
         if (o_wbv === 1'b1) nwb++;
         @(posedge clk); #1;
      end
      checks++; if (nwb != 0) begin errors++; $display("FAIL midrst_beats got %0d exp 0", nwb); end
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b exp 1", o_ready); end
      issue(1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 5'd9, 32'h40, 32'h0);
      checks++; if (r_dat !== 32'hA5A50F0F) begin errors++; $display("FAIL midrst_old_data got %h exp a5a50f0f", r_dat); end
   endtask

   task automatic test_random();
      int          e_lat;
      logic        e_we, e_mis, e_dchk, ld, st, rwe, un;
      logic [31:0] e_dat, a, od;
      logic [1:0]  sz;
      logic [4:0]  dst;
      int          kind;
      for (int u = 0; u < 2; u++) begin
         for (int w = 0; w < 16; w++) begin
            a  = ($urandom & 32'hFFFFFC00) | (32'h100 + 32'(w * 4));
            od = $urandom;
            model_op(u, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 5'd0, a, od, e_lat, e_we, e_mis, e_dat, e_dchk);
            issue(u, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 5'd0, a, od);
         end
         for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 2);
            ld   = (kind == 1);
            st   = (kind == 2) || (kind == 1 && $urandom_range(0, 1) == 1);
            rwe  = 1'($urandom);
            un   = 1'($urandom);
            sz   = 2'($urandom);
            dst  = 5'($urandom);
            od   = $urandom;
            a    = (kind == 0) ? $urandom : (($urandom & 32'hFFFFFC00) | (32'h100 + 32'($urandom_range(0, 63))));
            model_op(u, ld, st, rwe, sz, un, dst, a, od, e_lat, e_we, e_mis, e_dat, e_dchk);
            issue(u, ld, st, 1'b0, rwe, sz, un, dst, a, od);
            checks++; if (r_lat != e_lat) begin errors++; $display("FAIL rnd_latency u%0d n%0d got %0d exp %0d", u, n, r_lat, e_lat); end
            checks++; if (r_rl != e_lat) begin errors++; $display("FAIL rnd_ready_low u%0d n%0d got %0d exp %0d", u, n, r_rl, e_lat); end
            checks++; if (r_nwb != 1) begin errors++; $display("FAIL rnd_beats u%0d n%0d got %0d exp 1", u, n, r_nwb); end
            checks++; if (r_we !== e_we) begin errors++; $display("FAIL rnd_wb_we u%0d n%0d got %b exp %b", u, n, r_we, e_we); end
            checks++; if (r_mis !== e_mis) begin errors++; $display("FAIL rnd_misalign u%0d n%0d got %b exp %b", u, n, r_mis, e_mis); end
            checks++; if (r_num !== dst) begin errors++; $display("FAIL rnd_wb_num u%0d n%0d got %0d exp %0d", u, n, r_num, dst); end
            if (e_dchk) begin
               checks++; if (r_dat !== e_dat) begin errors++; $display("FAIL rnd_wb_data u%0d n%0d got %h exp %h", u, n, r_dat, e_dat); end
            end
         end
      end
   endtask

   task automatic test_halt_r0();
      int nwb;
      issue(0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 5'd0, 32'h0BADF00D, 32'h0);
      checks++; if (r_we !== 1'b0) begin errors++; $display("FAIL r0_wb_we got %b exp 0", r_we); end
      checks++; if (r_dat !== 32'h0BADF00D) begin errors++; $display("FAIL alu_data got %h exp 0badf00d", r_dat); end
      checks++; if (r_lat != 1) begin errors++; $display("FAIL alu_latency got %0d exp 1", r_lat); end
      issue(0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 5'd4, 32'h10, 32'h0);
      checks++; if (r_nwb != 0) begin errors++; $display("FAIL halt_beats got %0d exp 0", r_nwb); end
      checks++; if (o_halted !== 1'b1) begin errors++; $display("FAIL halt_flag got %b exp 1", o_halted); end
      checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL halt_ready got %b exp 0", o_ready); end
      d_load = 1'b0; d_store = 1'b0; d_halt = 1'b0; d_reg_we = 1'b1; d_dst = 5'd4; d_valid = 1'b1;
      nwb = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (o_wbv === 1'b1) nwb++;
      end
      d_valid = 1'b0;
      checks++; if (nwb != 0) begin errors++; $display("FAIL halt_ignores_valid got %0d exp 0", nwb); end
      checks++; if (o_halted !== 1'b1) begin errors++; $display("FAIL halt_sticky got %b exp 1", o_halted); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++; if (o_halted !== 1'b0) begin errors++; $display("FAIL halt_rst_flag got %b exp 0", o_halted); end
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL halt_rst_ready got %b exp 1", o_ready); end
   endtask

   initial begin
      test_reset();
      test_word_store_load();
      test_byte_merge();
      test_misalign();
      test_latency_wrap();
      test_reset_mid_store();
      test_random();
      test_halt_r0();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
